serial_add_ctrl: RTL and testbench
==================================

// Module: serial_add_ctrl
// PURPOSE
//  Bit-serial adder controller: sequences one full-adder cell over WIDTH cycles to add
//  two WIDTH-bit operands LSB first, with a carry flip-flop between bit slices.
//  Sits between a requester (start/done handshake) and the single 1-bit adder cell.
//  Trades area for latency; the result is held stable until the next accepted start.
// PARAMETERS
//  WIDTH    8   operand/result width in bits, >= 2
// PORTS
//  clk       in   1      rising-edge clock, single clock domain
//  reset     in   1      asynchronous, active-high; clears all state
//  start     in   1      request; sampled only in IDLE or DONE
//  a         in   WIDTH  operand A, captured on accepted start
//  b         in   WIDTH  operand B, captured on accepted start
//  cin       in   1      carry-in, captured on accepted start
//  busy      out  1      high while in SHIFT
//  done      out  1      one-cycle pulse, high in DONE
//  sum       out  WIDTH  result register, updated only on SHIFT->DONE
//  cout      out  1      carry out of bit WIDTH-1, updated with sum
//  overflow  out  1      signed overflow = carry into MSB XOR carry out, updated with sum
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, sum=0, cout=0, overflow=0; shift regs, carry, count=0.
//  States: IDLE, SHIFT, DONE (2-bit encoding, default arm returns to IDLE).
//  IDLE:  start=1 -> latch a,b into shift regs, carry<=cin, count<=0, go SHIFT; else stay.
//  SHIFT: each cycle the cell computes s=a_sh[0]^b_sh[0]^carry,
//         c=(a_sh[0]&b_sh[0])|(a_sh[0]&carry)|(b_sh[0]&carry).
//         On edge: a_sh,b_sh shift right 1; s shifted into MSB of work reg (work shifts right);
//         carry<=c; count<=count+1. When count==WIDTH-1 the incoming carry is saved as c_msb.
//         At count==WIDTH-1: sum<={s,work[WIDTH-1:1]}, cout<=c, overflow<=c^carry, go DONE.
//  DONE:  done=1 for exactly this cycle. start=1 -> accept as in IDLE (back-to-back, go SHIFT);
//         else go IDLE. sum/cout/overflow hold.
//  Latency: start sampled at edge E0; done high in the cycle after edge E0+WIDTH; one result
//         per WIDTH+1 cycles max throughput (back-to-back via DONE).
//  start while in SHIFT: ignored, no effect on operands or count (no queueing).
//  a/b/cin changes after accept: no effect on the in-flight add.
//  count width = $clog2(WIDTH); no wrap beyond WIDTH-1 is reachable.
//  Reset mid-SHIFT: immediate abort to IDLE; sum/cout/overflow cleared to 0; no done pulse.
//  busy = (state==SHIFT); done = (state==DONE); both decoded from registered state (glitch-free).
//  Arithmetic is unsigned modulo 2^WIDTH; cout is the 2^WIDTH bit; overflow is the
//  two's-complement flag. Result equals a+b+cin for all operand values.
// TESTING
//  1. WIDTH=8, a=0x3C b=0x0F cin=0, start 1 cycle -> busy 8 cycles, done at E0+8, sum=0x4B cout=0 ov=0.
//  2. a=0xFF b=0x01 cin=0 -> sum=0x00 cout=1 ov=0; a=0x7F b=0x01 -> sum=0x80 cout=0 ov=1.
//  3. a=0x80 b=0x80 cin=0 -> sum=0x00 cout=1 ov=1; a=0xFF b=0x00 cin=1 -> sum=0x00 cout=1 ov=0.
//  4. start held high through SHIFT with a/b changed mid-op -> result of first operands only;
//     start high in DONE -> second add begins next cycle, done pulses again 8 cycles later.
//  5. reset asserted at SHIFT cycle 4 (async, mid-cycle) -> busy=0, sum=0, no done; next start
//     with 0x01+0x01 -> sum=0x02 normally.
//  6. Random: 1000 operand/cin sets vs a+b+cin model; check sum/cout/ov, done width=1, latency=8.

Source files
------------

// File: rtl/serial_add_ctrl_if.sv
// Requester-side handshake and operand/result bundle for the bit-serial adder controller.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell reused over WIDTH cycles, LSB first,
// with a carry flip-flop between slices. Result held until the next accepted start.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    serial_add_ctrl_if.slave bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] work;
    logic             carry;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic             accept;
    logic             last;
    logic             s;
    logic             c;
    logic [WIDTH-1:0] shifted;

    assign accept  = bus.start && ((state == IDLE) || (state == DONE));
    assign last    = (count == CNT_W'(WIDTH - 1));

    // The single full-adder cell.
    assign s       = a_sh[0] ^ b_sh[0] ^ carry;
    assign c       = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    assign shifted = {s, work};

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, matching the hardware regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: state_nxt is defaulted before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = SHIFT;
            SHIFT:   if (last)      state_nxt = DONE;
            DONE:    state_nxt = bus.start ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == SHIFT);
        bus.done = (state == DONE);
    end

    // NOTE: the shift registers are ordinary flops, not a memory array, so they take the
    // async reset along with the rest; an aborted add leaves nothing stale behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sh   <= '0;
            b_sh   <= '0;
            work   <= '0;
            carry  <= 1'b0;
            count  <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (accept) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            carry <= bus.cin;
            count <= '0;
        end else if (state == SHIFT) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            work  <= shifted[WIDTH-1:1];
            carry <= c;
            count <= count + CNT_W'(1);
            if (last) begin
                // carry here is the carry into the MSB slice.
                sum_q  <= shifted;
                cout_q <= c;
                ovf_q  <= c ^ carry;
            end
        end
    end

    assign bus.sum      = sum_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed-vector and random bench for serial_add_ctrl (WIDTH = 8).
module tb_serial_add_ctrl;
    localparam int W = 8;

    logic clk;
    logic reset;

    serial_add_ctrl_if #(.WIDTH(W)) bus ();

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_ov;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
        end
    endtask

    task automatic wait_done(output int lat, output int nbusy);
        lat   = 0;
        nbusy = 0;
        while (!bus.done && lat < 40) begin
            if (bus.busy) nbusy++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_add(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                          input logic [W-1:0] es, input logic ec, input logic eo,
                          input string tag);
        int lat;
        int nbusy;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = va;
        bus.b     = vb;
        bus.cin   = vc;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.cin   = 1'($urandom);
        wait_done(lat, nbusy);
        check({tag, "_latency"}, lat, 8);
        check({tag, "_busy_cycles"}, nbusy, 8);
        check({tag, "_sum"}, bus.sum, es);
        check({tag, "_cout"}, bus.cout, ec);
        check({tag, "_ov"}, bus.overflow, eo);
        @(negedge clk);
        check({tag, "_done_width"}, bus.done, 1'b0);
    endtask

    vec_t vecs[10];

    initial begin
        int lat;
        int nbusy;
        int seen_done;

        vecs[0] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[4] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[6] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[8] = '{8'hC0, 8'hC0, 1'b0, 8'h80, 1'b1, 1'b0};
        vecs[9] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};

        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        reset     = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_busy", bus.busy, 1'b0);
        check("reset_done", bus.done, 1'b0);
        check("reset_sum", bus.sum, 8'h00);
        check("reset_cout", bus.cout, 1'b0);
        check("reset_ov", bus.overflow, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            do_add(vecs[i].a, vecs[i].b, vecs[i].cin,
                   vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ov,
                   $sformatf("vec%0d", i));
        end

        // start held through SHIFT with operands changed mid-add, then back-to-back via DONE.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h11;
        bus.b     = 8'h22;
        bus.cin   = 1'b0;
        @(negedge clk);
        bus.a     = 8'hFF;
        bus.b     = 8'hFF;
        wait_done(lat, nbusy);
        check("hold_latency", lat, 8);
        check("hold_done", bus.done, 1'b1);
        check("hold_sum", bus.sum, 8'h33);
        check("hold_cout", bus.cout, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b_busy_after_done", bus.busy, 1'b1);
        wait_done(lat, nbusy);
        check("b2b_latency", lat, 8);
        check("b2b_sum", bus.sum, 8'hFE);
        check("b2b_cout", bus.cout, 1'b1);
        check("b2b_ov", bus.overflow, 1'b0);
        @(negedge clk);
        check("b2b_done_width", bus.done, 1'b0);

        // Asynchronous reset in the middle of SHIFT.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h0F;
        bus.b     = 8'hF1;
        bus.cin   = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy_before", bus.busy, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", bus.busy, 1'b0);
        check("abort_done", bus.done, 1'b0);
        check("abort_sum", bus.sum, 8'h00);
        check("abort_cout", bus.cout, 1'b0);
        @(negedge clk);
        reset     = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done) seen_done++;
        end
        check("abort_no_done", seen_done, 0);
        do_add(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, "post_abort");

        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rc;
            logic [W:0]   full;
            logic         rov;
            ra   = W'($urandom);
            rb   = W'($urandom);
            rc   = 1'($urandom);
            full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            rov  = (ra[W-1] == rb[W-1]) && (full[W-1] != ra[W-1]);
            do_add(ra, rb, rc, full[W-1:0], full[W], rov, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
